// File: rtl/b06_irq_arbiter_if.sv
// Requester/handler side bus of the b06 round-robin interrupt arbiter.
// The B06_ARB_STATS_EN build adds the SVC_CNT/STAT_CLR statistics pair.
interface b06_irq_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] REQ;
  logic            HS_ACK;
  logic [NREQ-1:0] GRANT;
  logic [IDW-1:0]  GRANT_ID;
  logic            HS_REQ;
  logic            BUSY;
  logic            TMO_ERR;
`ifdef B06_ARB_STATS_EN
  logic [7:0]      SVC_CNT;
  logic            STAT_CLR;

  modport master (
    input  REQ, HS_ACK, STAT_CLR,
    output GRANT, GRANT_ID, HS_REQ, BUSY, TMO_ERR, SVC_CNT
  );

  modport slave (
    output REQ, HS_ACK, STAT_CLR,
    input  GRANT, GRANT_ID, HS_REQ, BUSY, TMO_ERR, SVC_CNT
  );
`else
  modport master (
    input  REQ, HS_ACK,
    output GRANT, GRANT_ID, HS_REQ, BUSY, TMO_ERR
  );

  modport slave (
    output REQ, HS_ACK,
    input  GRANT, GRANT_ID, HS_REQ, BUSY, TMO_ERR
  );
`endif
endinterface

// File: rtl/b06_irq_arbiter.sv
// Round-robin front-end sharing the b06 handler among NREQ requesters via a
// four-phase REQ/ACK handshake with timeout abort. Optional macro: B06_ARB_STATS_EN.
module b06_irq_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = 15
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  b06_irq_arbiter_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_ACK,
    S_WAIT_REL,
    S_RELEASE
  } state_t;

  localparam logic [7:0]     TMO_LAST = 8'(TMO - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr;
  logic            hs_req;
  logic            busy;
  logic            tmo_err;
  logic [7:0]      cnt;
  logic [NREQ-1:0] req_rot;
  logic [IDW-1:0]  win_id;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + IDW'(1);
  endfunction

  // Rotate the request vector so bit 0 is the pointer position; the lowest
  // set bit of the rotated vector is the round-robin winner.
  always_comb begin
    req_rot = NREQ'({bus.REQ, bus.REQ} >> ptr);
    win_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) win_id = wrap_add(ptr, i);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= '0;
      hs_req   <= 1'b0;
      busy     <= 1'b0;
      tmo_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      tmo_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.REQ) begin
            grant    <= NREQ'(1) << win_id;
            grant_id <= win_id;
            busy     <= 1'b1;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          hs_req <= 1'b1;
          cnt    <= '0;
          state  <= S_WAIT_ACK;
        end
        // Ack is checked before the timeout so a last-cycle ack still completes.
        S_WAIT_ACK: begin
          if (bus.HS_ACK) begin
            hs_req <= 1'b0;
            cnt    <= '0;
            state  <= S_WAIT_REL;
          end else if (cnt == TMO_LAST) begin
            hs_req  <= 1'b0;
            tmo_err <= 1'b1;
            state   <= S_RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT_REL: begin
          if (!bus.HS_ACK) begin
            state <= S_RELEASE;
          end else if (cnt == TMO_LAST) begin
            tmo_err <= 1'b1;
            state   <= S_RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          grant <= '0;
          ptr   <= next_id(grant_id);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.GRANT    = grant;
  assign bus.GRANT_ID = grant_id;
  assign bus.HS_REQ   = hs_req;
  assign bus.BUSY     = busy;
  assign bus.TMO_ERR  = tmo_err;

`ifdef B06_ARB_STATS_EN
  logic [7:0] svc_cnt;

  // Counts only clean completions (ack released); clear beats increment.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      svc_cnt <= '0;
    end else if (bus.STAT_CLR) begin
      svc_cnt <= '0;
    end else if (state == S_WAIT_REL && !bus.HS_ACK && svc_cnt != 8'hFF) begin
      svc_cnt <= svc_cnt + 8'd1;
    end
  end

  assign bus.SVC_CNT = svc_cnt;
`else
  // No statistics counter in this build.
`endif

endmodule

// File: tb/tb_b06_irq_arbiter.sv
// Self-checking bench for b06_irq_arbiter: directed and randomized services
// checked against a timeline model derived from the arbitration/handshake rules.
module tb_b06_irq_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 15;

  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b0;

  b06_irq_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  b06_irq_arbiter #(.NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus.master)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int svc_m  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] mask, input int p);
    logic [NREQ-1:0] sh;
    for (int i = 0; i < NREQ; i++) begin
      int c;
      c  = (p + i) % NREQ;
      sh = mask >> c;
      if (sh[0]) return c;
    end
    return 0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_grant"},   32'(bus.GRANT),   32'd0);
    check({tag, "_hs_req"},  32'(bus.HS_REQ),  32'd0);
    check({tag, "_busy"},    32'(bus.BUSY),    32'd0);
    check({tag, "_tmo_err"}, 32'(bus.TMO_ERR), 32'd0);
  endtask

  task automatic idle_cycles(input int n, input logic ack);
    bus.REQ    = '0;
    bus.HS_ACK = ack;
    for (int k = 0; k < n; k++) begin
      @(negedge CLOCK);
      check_quiet("idle");
    end
    bus.HS_ACK = 1'b0;
  endtask

  // One full service starting from IDLE at a negedge. Handler raises HS_ACK
  // ack_dly cycles into WAIT_ACK and keeps it up for hold cycles.
  task automatic serve(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] mid_req,
                       input int ack_dly, input int hold, input bit clr);
    int w, rel_t, hs_end;
    bit ab_ack, abort;
    logic [NREQ-1:0] g;
    w = pick(mask, ptr_m);
    g = NREQ'(1) << w;
    ab_ack = (ack_dly >= TMO);
    if (ab_ack) begin
      rel_t  = TMO - 1;
      abort  = 1'b1;
      hs_end = TMO - 1;
    end else begin
      rel_t  = ack_dly + ((hold < TMO) ? hold : TMO);
      abort  = (hold > TMO);
      hs_end = ack_dly;
    end
    if (clr) svc_m = 0;
    else if (!abort && svc_m < 255) svc_m++;

    bus.REQ = mask;
    @(negedge CLOCK);
    check("grant",         32'(bus.GRANT),    32'(g));
    check("grant_id",      32'(bus.GRANT_ID), 32'(w));
    check("grant_hs_req",  32'(bus.HS_REQ),   32'd0);
    check("grant_busy",    32'(bus.BUSY),     32'd1);
    bus.REQ = mid_req;
    if (ack_dly == 0) bus.HS_ACK = 1'b1;

    for (int t = 0; t <= rel_t + 2; t++) begin
      @(negedge CLOCK);
      check("svc_hs_req",  32'(bus.HS_REQ),  32'(t <= hs_end));
      check("svc_grant",   32'(bus.GRANT),   (t <= rel_t + 1) ? 32'(g) : 32'd0);
      check("svc_busy",    32'(bus.BUSY),    32'(t <= rel_t + 1));
      check("svc_tmo_err", 32'(bus.TMO_ERR), 32'((t == rel_t + 1) && abort));
      if (t == rel_t + 2) check("held_grant_id", 32'(bus.GRANT_ID), 32'(w));
      bus.HS_ACK = !ab_ack && (t >= ack_dly) && (t < ack_dly + hold) && (t <= rel_t + 1);
`ifdef B06_ARB_STATS_EN
      bus.STAT_CLR = clr && (t == rel_t);
      if (t == rel_t + 2) check("svc_cnt", 32'(bus.SVC_CNT), 32'(svc_m));
`endif
    end
    ptr_m = (w + 1) % NREQ;
  endtask

  initial begin
    bus.REQ    = '0;
    bus.HS_ACK = 1'b0;
`ifdef B06_ARB_STATS_EN
    bus.STAT_CLR = 1'b0;
`endif
    RESET_N = 1'b0;
    #1;
    check_quiet("reset");
    check("reset_grant_id", 32'(bus.GRANT_ID), 32'd0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    idle_cycles(10, 1'b0);

    // Round-robin with all requesting and an immediate-ack handler.
    for (int k = 0; k < 5; k++) serve(4'b1111, 4'b1111, 0, 1, 1'b0);
    serve(4'b1001, 4'b1001, 0, 1, 1'b0);
    serve(4'b1001, 4'b0000, 1, 2, 1'b0);

    // Single service with REQ dropped mid-service.
    serve(4'b0100, 4'b0000, 3, 2, 1'b0);

    // Timeout with ack stuck low, then requester 1 wins next.
    serve(4'b0001, 4'b0011, 255, 1, 1'b0);
    serve(4'b0011, 4'b0011, 2, 1, 1'b0);

    // Timeout with ack stuck high, then ack lingering in IDLE is ignored.
    serve(4'b0001, 4'b0000, 1, 100, 1'b0);
    idle_cycles(3, 1'b1);

    // Last-cycle ack and exact-limit release both complete normally.
    serve(4'b0010, 4'b0000, TMO - 1, TMO, 1'b0);

    for (int k = 0; k < 30; k++) begin
      serve(NREQ'($urandom_range(1, 15)), NREQ'($urandom_range(0, 15)),
            int'($urandom_range(0, 18)), int'($urandom_range(1, 18)), 1'b0);
    end

    // Asynchronous reset in WAIT_ACK with a non-zero pointer.
    serve(4'b0010, 4'b0000, 0, 1, 1'b0);
    bus.REQ = 4'b1111;
    @(negedge CLOCK);
    check("pre_reset_grant", 32'(bus.GRANT), 32'(NREQ'(1) << pick(4'b1111, ptr_m)));
    @(negedge CLOCK);
    check("pre_reset_hs_req", 32'(bus.HS_REQ), 32'd1);
    #3;
    RESET_N = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_grant_id", 32'(bus.GRANT_ID), 32'd0);
`ifdef B06_ARB_STATS_EN
    check("async_reset_svc_cnt", 32'(bus.SVC_CNT), 32'd0);
`endif
    ptr_m = 0;
    svc_m = 0;
    bus.REQ = '0;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    idle_cycles(2, 1'b0);

    // Three completions and one abort, then a clear colliding with a completion.
    serve(4'b1111, 4'b1111, 0, 3, 1'b0);
    serve(4'b1111, 4'b1111, 2, 1, 1'b0);
    serve(4'b1111, 4'b1111, 1, 2, 1'b0);
    serve(4'b1111, 4'b0000, 255, 1, 1'b0);
    serve(4'b0101, 4'b0000, 1, 1, 1'b1);
    idle_cycles(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
